// File: rtl/rate_pkg.sv
// Shared types and period arithmetic for the rate divider / tick generator.
// Periods are expressed as P-1 so the down-counter reloads straight from this value.
package rate_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2
  } state_e;

  localparam logic [1:0] SPEED_EVERY = 2'b00;
  localparam logic [1:0] SPEED_1X    = 2'b01;
  localparam logic [1:0] SPEED_2X    = 2'b10;
  localparam logic [1:0] SPEED_4X    = 2'b11;

  // Cycles-per-tick minus one; callers narrow the result to their counter width.
  function automatic longint unsigned period_m1(input logic [1:0] speed,
                                                input longint unsigned clk_hz);
    longint unsigned p;
    case (speed)
      SPEED_EVERY: p = 64'd1;
      SPEED_1X:    p = clk_hz;
      SPEED_2X:    p = 2 * clk_hz;
      default:     p = 4 * clk_hz;
    endcase
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/rate_divider_tick_if.sv
// Control/status bundle between the switch/button front panel and the tick generator.
// No valid/ready handshake here: tick is a one-cycle qualifier, every other signal is level.
interface rate_divider_tick_if #(
  parameter int CNT_W = 28
);
  import rate_pkg::*;

  logic             enable;
  logic [1:0]       speed;
  logic             step_n;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] count_q;
  state_e           state_dbg;

  modport master (
    output enable, speed, step_n,
    input  tick, running, count_q, state_dbg
  );

  modport slave (
    input  enable, speed, step_n,
    output tick, running, count_q, state_dbg
  );

endinterface

// File: rtl/step_sync.sv
// Brings the asynchronous active-low pushbutton into the clock domain and
// produces a single-cycle pulse on each press (falling edge of step_n).
module step_sync (
  input  logic clock,
  input  logic clear,
  input  logic step_n,
  output logic step_fall
);

  logic sync1;
  logic sync2;
  logic prev;

  // Flops reset to 1 (button released) so leaving reset never looks like a press.
  always_ff @(posedge clock) begin
    if (!clear) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= step_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign step_fall = prev & ~sync2;

endmodule

// File: rtl/rate_divider_tick.sv
// Divides the board clock into a one-cycle tick at a selectable rate, with a
// run / pause / single-step FSM driven by the enable switch and step button.
module rate_divider_tick
  import rate_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          CNT_W  = 28
) (
  input  logic             clock,
  input  logic             clear,
  rate_divider_tick_if.slave bus
);

  localparam logic [CNT_W-1:0] PM1_EVERY = CNT_W'(period_m1(SPEED_EVERY, 64'(CLK_HZ)));
  localparam logic [CNT_W-1:0] PM1_1X    = CNT_W'(period_m1(SPEED_1X,    64'(CLK_HZ)));
  localparam logic [CNT_W-1:0] PM1_2X    = CNT_W'(period_m1(SPEED_2X,    64'(CLK_HZ)));
  localparam logic [CNT_W-1:0] PM1_4X    = CNT_W'(period_m1(SPEED_4X,    64'(CLK_HZ)));

  state_e           state;
  logic             tick_r;
  logic             running_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       speed_r;
  logic             speed_chg;
  logic             step_fall;
  logic [CNT_W-1:0] pm1;

  step_sync u_step_sync (
    .clock     (clock),
    .clear     (clear),
    .step_n    (bus.step_n),
    .step_fall (step_fall)
  );

  always_comb begin
    pm1 = PM1_4X;
    case (bus.speed)
      SPEED_EVERY: pm1 = PM1_EVERY;
      SPEED_1X:    pm1 = PM1_1X;
      SPEED_2X:    pm1 = PM1_2X;
      default:     pm1 = PM1_4X;
    endcase
  end

  assign speed_chg = (bus.speed != speed_r);

  // running is registered as "next state is RUN", so it changes on the same edge as state.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= ST_PAUSE;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
      count_r   <= pm1;
      speed_r   <= bus.speed;
    end else begin
      speed_r <= bus.speed;
      case (state)
        ST_PAUSE: begin
          if (bus.enable) begin
            state     <= ST_RUN;
            running_r <= 1'b1;
            tick_r    <= 1'b0;
            if (speed_chg) count_r <= pm1;
          end else if (step_fall) begin
            state     <= ST_STEP;
            running_r <= 1'b0;
            tick_r    <= 1'b1;
            count_r   <= pm1;
          end else begin
            running_r <= 1'b0;
            tick_r    <= 1'b0;
            if (speed_chg) count_r <= pm1;
          end
        end

        ST_STEP: begin
          state     <= ST_PAUSE;
          running_r <= 1'b0;
          tick_r    <= 1'b0;
          if (speed_chg) count_r <= pm1;
        end

        ST_RUN: begin
          if (!bus.enable) begin
            state     <= ST_PAUSE;
            running_r <= 1'b0;
            tick_r    <= 1'b0;
          end else begin
            running_r <= 1'b1;
            // A speed change restarts the period and suppresses the tick, even at zero.
            if (speed_chg) begin
              count_r <= pm1;
              tick_r  <= 1'b0;
            end else if (count_r == '0) begin
              count_r <= pm1;
              tick_r  <= 1'b1;
            end else begin
              count_r <= count_r - CNT_W'(1);
              tick_r  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= ST_PAUSE;
          running_r <= 1'b0;
          tick_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick      = tick_r;
  assign bus.running   = running_r;
  assign bus.count_q   = count_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_rate_divider_tick.sv
// Scenario bench for rate_divider_tick at CLK_HZ=4 (periods 1/4/8/16); each edge's
// expected {state, tick, running, count_q} is queued up front and popped after the edge.
module tb_rate_divider_tick;
  import rate_pkg::*;

  localparam int CLK_HZ = 4;
  localparam int CNT_W  = 28;
  localparam int W      = CNT_W + 4;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  rate_divider_tick_if #(.CNT_W(CNT_W)) bus ();

  rate_divider_tick #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;
  logic [W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  task automatic push(input logic [1:0] st, input logic tk, input logic rn, input int cnt);
    exp_q.push_back({st, tk, rn, CNT_W'(cnt)});
  endtask

  function automatic logic [W-1:0] observed();
    return {bus.state_dbg, bus.tick, bus.running, bus.count_q};
  endfunction

  task automatic test_reset();
    push(0, 0, 0, 0);
    push(0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      clear = 1'b0; bus.enable = 1'b1; bus.speed = 2'b00; bus.step_n = 1'b1;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_fast_run();
    push(1, 0, 1, 0);
    for (int k = 1; k < 6; k++) push(1, 1, 1, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL fast_run c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_speed1_run();
    push(0, 0, 0, 0);
    push(0, 0, 0, 3);
    push(1, 0, 1, 3);
    push(1, 0, 1, 2); push(1, 0, 1, 1); push(1, 0, 1, 0); push(1, 1, 1, 3);
    push(1, 0, 1, 2); push(1, 0, 1, 1); push(1, 0, 1, 0); push(1, 1, 1, 3);
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      if (c == 0) bus.enable = 1'b0;
      if (c == 1) bus.speed  = 2'b01;
      if (c == 2) bus.enable = 1'b1;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL speed1_run c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_speed_change();
    push(1, 0, 1, 2);
    push(1, 0, 1, 15);
    for (int k = 2; k <= 16; k++) push(1, 0, 1, 16 - k);
    push(1, 1, 1, 15);
    for (int c = 0; c < 18; c++) begin
      @(negedge clock);
      if (c == 1) bus.speed = 2'b11;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL speed_change c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_pause_step();
    push(1, 0, 1, 3); push(1, 0, 1, 2); push(1, 0, 1, 1);
    for (int k = 3; k <= 6; k++) push(0, 0, 0, 1);
    push(2, 1, 0, 3);
    for (int k = 8; k <= 19; k++) push(0, 0, 0, 3);
    push(2, 1, 0, 3);
    for (int k = 21; k <= 23; k++) push(0, 0, 0, 3);
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (c == 0)  bus.speed  = 2'b01;
      if (c == 3)  bus.enable = 1'b0;
      if (c == 5)  bus.step_n = 1'b0;
      if (c == 15) bus.step_n = 1'b1;
      if (c == 18) bus.step_n = 1'b0;
      if (c == 22) bus.step_n = 1'b1;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL pause_step c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_step_while_run();
    push(1, 0, 1, 3);
    for (int k = 1; k < 13; k++) begin
      if (k % 4 == 0) push(1, 1, 1, 3);
      else            push(1, 0, 1, 3 - (k % 4));
    end
    for (int c = 0; c < 13; c++) begin
      @(negedge clock);
      if (c == 0) bus.enable = 1'b1;
      if (c == 1) bus.step_n = 1'b0;
      if (c == 3) bus.step_n = 1'b1;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL step_while_run c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_clear_mid_run();
    push(1, 0, 1, 2);
    push(0, 0, 0, 3);
    push(1, 0, 1, 3);
    push(1, 0, 1, 2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (c == 1) clear = 1'b0;
      if (c == 2) clear = 1'b1;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL clear_mid_run c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_clear_discards_step();
    push(0, 0, 0, 2);
    push(0, 0, 0, 2);
    for (int k = 2; k < 6; k++) push(0, 0, 0, 3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 0) bus.enable = 1'b0;
      if (c == 1) bus.step_n = 1'b0;
      if (c == 2) begin
        bus.step_n = 1'b1;
        clear      = 1'b0;
      end
      if (c == 3) clear = 1'b1;
      @(posedge clock); #1;
      got = observed(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL clear_discards_step c%0d got %h exp %h", c, got, exp_v);
      end
    end
  endtask

  initial begin
    clear      = 1'b0;
    bus.enable = 1'b1;
    bus.speed  = 2'b00;
    bus.step_n = 1'b1;
    test_reset();
    test_fast_run();
    test_speed1_run();
    test_speed_change();
    test_pause_step();
    test_step_while_run();
    test_clear_mid_run();
    test_clear_discards_step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
